pc_fetch_sequencer: RTL

- Owns the fetch PC. Issues one-outstanding fetch requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents the fetched instruction with its PC and PC+4 to decode through a valid/stall output register.
- Applies taken branch/jump redirects from the branch-target adder (PCTarget).
- Squashes wrong-path fetches and flags memory timeouts.

---
 rtl/pc_fetch_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pc_fetch_sequencer
// Brief  : Fetch-PC owner. It issues one outstanding instruction-memory
//          request at a time and presents Instr/PC/PCPlus4 to decode.
// Rev    : 1.0  initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCTarget,
    input  logic        redirect_valid,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        target_misaligned,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_fetchPc;
    logic [31:0] r_reqPc;
    logic        r_discard;
    logic [7:0]  r_waitCnt;

    logic w_consume;
    logic w_redirect;
    logic w_transfer;
    logic w_rspHit;
    logic w_rspLoad;

    always_comb begin
        w_stateNext    = r_state;
        imem_req_valid = 1'b0;
        imem_req_addr  = 32'h0;
        w_consume      = instr_valid && !stall;
        w_redirect     = w_consume && redirect_valid;
        w_rspHit       = (r_state == S_WAIT) && imem_rsp_valid;
        w_rspLoad      = w_rspHit && !r_discard;

        // A new request only goes out when the output register will be free.
        if (r_state == S_REQ) begin
            imem_req_valid = !instr_valid || !stall;
            imem_req_addr  = r_fetchPc;
        end
        w_transfer = imem_req_valid && imem_req_ready;

        case (r_state)
            S_IDLE:  w_stateNext = S_REQ;
            S_REQ:   if (w_transfer) w_stateNext = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) w_stateNext = S_REQ;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_fetchPc         <= RESET_PC;
            r_reqPc           <= 32'h0;
            r_discard         <= 1'b0;
            r_waitCnt         <= 8'h0;
            instr_valid       <= 1'b0;
            Instr             <= 32'h0;
            PC                <= 32'h0;
            PCPlus4           <= 32'h0;
            target_misaligned <= 1'b0;
            fetch_timeout     <= 1'b0;
        end else begin
            r_state <= w_stateNext;

            if (w_transfer) begin
                r_reqPc   <= r_fetchPc;
                r_waitCnt <= 8'h0;
            end else if (r_state == S_WAIT && r_waitCnt != 8'hFF) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end

            // Sticky: set once TIMEOUT_CYCLES wait cycles have passed unanswered.
            if (r_state == S_WAIT && !imem_rsp_valid && r_waitCnt >= c_TIMEOUT_LAST) begin
                fetch_timeout <= 1'b1;
            end

            if (w_redirect) begin
                r_fetchPc <= {PCTarget[31:2], 2'b00};
            end else if (w_rspLoad) begin
                r_fetchPc <= r_reqPc + 32'd4;
            end

            target_misaligned <= w_redirect && (PCTarget[1:0] != 2'b00);

            // The fetch in flight at a redirect belongs to the wrong path.
            if (w_redirect && ((r_state == S_WAIT && !imem_rsp_valid) || w_transfer)) begin
                r_discard <= 1'b1;
            end else if (w_rspHit) begin
                r_discard <= 1'b0;
            end

            if (w_rspLoad) begin
                instr_valid <= 1'b1;
                Instr       <= imem_rsp_data;
                PC          <= r_reqPc;
                PCPlus4     <= r_reqPc + 32'd4;
            end else if (w_consume) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
